// File: rtl/sweep_pkg.sv
// sweep_pkg: shared state encoding, default widths and the MISR step function
package sweep_pkg;
  typedef enum logic [2:0] {S_IDLE, S_DRIVE, S_SAMPLE, S_HOLD, S_DONE} sweep_state_t;
  localparam int DEF_IN_W = 6;
  localparam int DEF_OUT_W = 20;
  localparam logic [DEF_OUT_W-1:0] DEF_POLY = 20'h00009;
  // The signature width is an argument, so one function serves any register up to 32 bits
  function automatic logic [31:0] misr_step(input logic [31:0] sig, input logic [31:0] poly,
                                            input logic [31:0] din, input int w);
    logic [31:0] mask;
    mask = (w >= 32) ? '1 : (32'd1 << w) - 32'd1;
    return ((sig << 1) ^ (sig[w-1] ? poly : 32'd0) ^ din) & mask;
  endfunction
endpackage

// File: rtl/dut_sweep_collector_if.sv
// dut_sweep_collector_if: stimulus/response path to the generated block plus the response stream
interface dut_sweep_collector_if import sweep_pkg::*; #(
  parameter int IN_W = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W
) ();
  logic [IN_W-1:0] stim_data;
  logic [OUT_W-1:0] resp_data;
  logic rsp_valid;
  logic rsp_ready;
  logic [OUT_W-1:0] rsp_data;
  logic [IN_W-1:0] rsp_index;
  modport master (output stim_data, rsp_valid, rsp_data, rsp_index, input resp_data, rsp_ready);
  modport slave (input stim_data, rsp_valid, rsp_data, rsp_index, output resp_data, rsp_ready);
endinterface

// File: rtl/misr_reg.sv
// misr_reg: OUT_W-bit multiple-input signature register with seed load
module misr_reg import sweep_pkg::*; #(
  parameter int OUT_W = DEF_OUT_W,
  parameter logic [OUT_W-1:0] POLY = OUT_W'(DEF_POLY)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic [OUT_W-1:0] seed,
  input  logic en,
  input  logic [OUT_W-1:0] din,
  output logic [OUT_W-1:0] sig
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sig <= '0;
    else if (load) sig <= seed;
    else if (en) sig <= OUT_W'(misr_step(32'(sig), 32'(POLY), 32'(din), OUT_W));
endmodule

// File: rtl/dut_sweep_collector.sv
// dut_sweep_collector: sweeps every stimulus code through a combinational block,
// streams each settled response and folds it into a MISR signature
module dut_sweep_collector import sweep_pkg::*; #(
  parameter int IN_W = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int SETTLE = 1,
  parameter logic [OUT_W-1:0] POLY = OUT_W'(DEF_POLY),
  parameter logic [OUT_W-1:0] SEED = '1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  dut_sweep_collector_if.master bus,
  output logic busy,
  output logic done,
  output logic [OUT_W-1:0] signature
);
  sweep_state_t state, nstate;
  logic [3:0] cnt;
  logic [IN_W-1:0] stim, idx;
  logic [OUT_W-1:0] data;
  logic valid, arm, acc, last;
  assign arm = (state == S_IDLE || state == S_DONE) && start;
  assign acc = state == S_HOLD && valid && bus.rsp_ready;
  assign last = &stim;
  assign bus.stim_data = stim;
  assign bus.rsp_valid = valid;
  assign bus.rsp_data = data;
  assign bus.rsp_index = idx;
  always_comb begin
    nstate = state;
    busy = state == S_DRIVE || state == S_SAMPLE || state == S_HOLD;
    done = state == S_DONE;
    case (state)
      S_IDLE, S_DONE: nstate = start ? S_DRIVE : state;
      S_DRIVE: nstate = cnt == '0 ? S_SAMPLE : S_DRIVE;
      S_SAMPLE: nstate = S_HOLD;
      S_HOLD: nstate = acc ? (last ? S_DONE : S_DRIVE) : S_HOLD;
      default: nstate = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      cnt <= '0;
      stim <= '0;
      valid <= 1'b0;
      data <= '0;
      idx <= '0;
    end else begin
      state <= nstate;
      if (arm) begin
        stim <= '0;
        cnt <= 4'(SETTLE - 1);
      end else if (state == S_DRIVE) cnt <= cnt - 4'd1;
      else if (acc && !last) begin
        stim <= stim + 1'b1;
        cnt <= 4'(SETTLE - 1);
      end
      // The captured response stays put until the sink takes it
      if (state == S_SAMPLE) begin
        valid <= 1'b1;
        data <= bus.resp_data;
        idx <= stim;
      end else if (acc) valid <= 1'b0;
    end
  misr_reg #(.OUT_W(OUT_W), .POLY(POLY)) u_misr (
    .clk(clk),
    .rst_n(rst_n),
    .load(arm),
    .seed(SEED),
    .en(state == S_SAMPLE),
    .din(bus.resp_data),
    .sig(signature)
  );
endmodule
